// File: rtl/vector_load_unit_if.sv
// Bus bundle for vector_load_unit: load request, memory handshake and register-write port.
// The slave modport is the load unit; the master modport is whoever drives requests and
// models memory and the register file.
interface vector_load_unit_if;
  logic        Start;
  logic [31:0] Address;
  logic [3:0]  LaneMask;
  logic [1:0]  DestPos;
  logic        MemRead;
  logic [31:0] MemAddr;
  logic [31:0] MemData;
  logic        MemValid;
  logic [31:0] Data0;
  logic [31:0] Data1;
  logic [31:0] Data2;
  logic [31:0] Data3;
  logic        DataOut0;
  logic        DataOut1;
  logic        DataOut2;
  logic        DataOut3;
  logic [1:0]  DataPos;
  logic        RegWrite;
  logic        Busy;
  logic        Done;
  logic        Error;

  modport master (
    output Start, Address, LaneMask, DestPos, MemData, MemValid,
    input  MemRead, MemAddr, Data0, Data1, Data2, Data3,
    input  DataOut0, DataOut1, DataOut2, DataOut3, DataPos, RegWrite, Busy, Done, Error
  );

  modport slave (
    input  Start, Address, LaneMask, DestPos, MemData, MemValid,
    output MemRead, MemAddr, Data0, Data1, Data2, Data3,
    output DataOut0, DataOut1, DataOut2, DataOut3, DataPos, RegWrite, Busy, Done, Error
  );
endinterface

// File: rtl/vector_load_unit.sv
// Vector load unit: gathers up to four 32-bit lanes from memory, one outstanding read at a
// time, then writes them to a destination register in a single strobe.
// Optional macro VLU_TIMEOUT_EN adds a WAIT-state watchdog that aborts with Error.
// All outputs are registered from the next state, so they line up with the FSM state.
module vector_load_unit #(
  parameter int unsigned ADDR_STRIDE    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic               clk,
  input logic               reset,
  vector_load_unit_if.slave bus_io
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StReq    = 3'd1;
  localparam logic [2:0] StWait   = 3'd2;
  localparam logic [2:0] StWrite  = 3'd3;
  localparam logic [2:0] StFinish = 3'd4;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  logic [2:0]       state_q, state_d;
  logic [31:0]      base_q, base_d;
  logic [3:0]       mask_q, mask_d;
  logic [3:0]       pend_q, pend_d;   // lanes still to be fetched
  logic [1:0]       dest_q, dest_d;
  logic [3:0][31:0] buf_q, buf_d;
  logic [1:0]       cur_lane, next_lane;
  logic             err_d;

  logic             mem_read_q, reg_write_q, done_q, err_q, busy_q;
  logic [31:0]      mem_addr_q;
  logic [3:0][31:0] data_q;
  logic [3:0]       data_out_q;
  logic [1:0]       data_pos_q;

`ifdef VLU_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
`endif

  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) r = 2'(i);
    end
    return r;
  endfunction

  assign cur_lane  = lowest_set(pend_q);
  assign next_lane = lowest_set(pend_d);

  // Next-state logic: request latching, lane walk and completion.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    mask_d  = mask_q;
    pend_d  = pend_q;
    dest_d  = dest_q;
    buf_d   = buf_q;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus_io.Start) begin
          if (bus_io.DestPos == 2'b11) begin
            err_d = 1'b1;
          end else begin
            base_d  = bus_io.Address;
            mask_d  = bus_io.LaneMask;
            pend_d  = bus_io.LaneMask;
            dest_d  = bus_io.DestPos;
            state_d = (bus_io.LaneMask == 4'b0) ? StFinish : StReq;
          end
        end
      end
      StReq: state_d = StWait;
      StWait: begin
        if (bus_io.MemValid) begin
          buf_d[cur_lane]  = bus_io.MemData;
          pend_d[cur_lane] = 1'b0;
          state_d          = (pend_d == 4'b0) ? StWrite : StReq;
        end
`ifdef VLU_TIMEOUT_EN
        else if (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
`endif
      end
      StWrite:  state_d = StFinish;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

`ifdef VLU_TIMEOUT_EN
  // Watchdog counts consecutive WAIT cycles; restarts on every fresh entry to WAIT.
  always_comb begin
    wait_cnt_d = '0;
    if (state_q == StWait && state_d == StWait) wait_cnt_d = wait_cnt_q + CntW'(1);
  end

  // Watchdog register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wait_cnt_q <= '0;
    else       wait_cnt_q <= wait_cnt_d;
  end
`endif

  // FSM state and latched request context.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      base_q  <= '0;
      mask_q  <= '0;
      pend_q  <= '0;
      dest_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      dest_q  <= dest_d;
      buf_q   <= buf_d;
    end
  end

  // Output registers, decoded from the next state so they coincide with the state itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_read_q  <= 1'b0;
      mem_addr_q  <= '0;
      reg_write_q <= 1'b0;
      data_out_q  <= '0;
      data_pos_q  <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      mem_read_q  <= (state_d == StReq);
      // 32-bit wrap-around is intended for addresses near the top of memory.
      if (state_d == StReq) mem_addr_q <= base_d + 32'(ADDR_STRIDE) * 32'(next_lane);
      reg_write_q <= (state_d == StWrite);
      data_out_q  <= (state_d == StWrite) ? mask_d : 4'b0;
      if (state_d == StWrite) begin
        data_pos_q <= dest_d;
        for (int i = 0; i < 4; i++) data_q[i] <= mask_d[i] ? buf_d[i] : 32'h0;
      end
      done_q <= (state_d == StFinish);
      err_q  <= err_d;
      busy_q <= (state_d != StIdle);
    end
  end

  assign bus_io.MemRead  = mem_read_q;
  assign bus_io.MemAddr  = mem_addr_q;
  assign bus_io.Data0    = data_q[0];
  assign bus_io.Data1    = data_q[1];
  assign bus_io.Data2    = data_q[2];
  assign bus_io.Data3    = data_q[3];
  assign bus_io.DataOut0 = data_out_q[0];
  assign bus_io.DataOut1 = data_out_q[1];
  assign bus_io.DataOut2 = data_out_q[2];
  assign bus_io.DataOut3 = data_out_q[3];
  assign bus_io.DataPos  = data_pos_q;
  assign bus_io.RegWrite = reg_write_q;
  assign bus_io.Busy     = busy_q;
  assign bus_io.Done     = done_q;
  assign bus_io.Error    = err_q;

endmodule

// File: tb/tb_vector_load_unit.sv
// Self-checking bench for vector_load_unit: directed table, reset/busy corner cases and
// randomized loads against a lane-level reference model.
module tb_vector_load_unit;

  localparam int unsigned Stride = 4;
  localparam int unsigned Tmo    = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  vector_load_unit_if bus ();

  vector_load_unit #(
    .ADDR_STRIDE    (Stride),
    .TIMEOUT_CYCLES (Tmo)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      addr;
    logic [3:0]       mask;
    logic [1:0]       dest;
    int               lat;
    int               n_reads;
    logic [3:0][31:0] rd;
    logic [3:0][31:0] d;
    logic [3:0]       dout;
    logic [1:0]       dpos;
    int               n_wr;
    int               n_done;
    int               n_err;
    int               wr_lat;
    int               err_lat;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned cyc = 0;

  // memory model state
  int          mem_lat  = 1;
  bit          mem_mute = 1'b0;
  bit          pend_v   = 1'b0;
  int          pend_n   = 0;
  logic [31:0] pend_a   = '0;

  // monitor state
  logic [31:0]      rd_q[$];
  int               wr_cnt = 0, done_cnt = 0, err_cnt = 0, bad_cnt = 0;
  int unsigned      wr_cyc = 0, done_cyc = 0, err_cyc = 0;
  logic [3:0][31:0] wr_data = '0;
  logic [3:0]       wr_dout = '0;
  logic [1:0]       wr_dpos = '0;
  bit               prev_rd = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a >= 32'h100 && a < 32'h110) return 32'hA0 + ((a - 32'h100) >> 2);
    return a ^ 32'hC0DE_0000;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: answers each read mem_lat cycles after MemRead is seen; junk data otherwise.
  always @(posedge clk) begin
    #1;
    bus.MemValid = 1'b0;
    bus.MemData  = $urandom;
    if (pend_v) begin
      if (pend_n <= 1) begin
        bus.MemValid = 1'b1;
        bus.MemData  = mem_word(pend_a);
        pend_v       = 1'b0;
      end else begin
        pend_n--;
      end
    end
    if (bus.MemRead && !mem_mute) begin
      pend_v = 1'b1;
      pend_n = mem_lat;
      pend_a = bus.MemAddr;
    end
  end

  // Monitor: logs reads and strobes, and counts protocol hygiene violations.
  always @(posedge clk) begin
    #1;
    if (bus.MemRead) rd_q.push_back(bus.MemAddr);
    if (bus.MemRead && prev_rd) bad_cnt++;
    prev_rd = bus.MemRead;
    if (bus.RegWrite) begin
      wr_cnt++;
      wr_cyc  = cyc;
      wr_data = {bus.Data3, bus.Data2, bus.Data1, bus.Data0};
      wr_dout = {bus.DataOut3, bus.DataOut2, bus.DataOut1, bus.DataOut0};
      wr_dpos = bus.DataPos;
    end else if ({bus.DataOut3, bus.DataOut2, bus.DataOut1, bus.DataOut0} != 4'b0) begin
      bad_cnt++;
    end
    if (bus.Done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.Error) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".MemRead"},  32'(bus.MemRead), 0);
    check({tag, ".MemAddr"},  bus.MemAddr, 0);
    check({tag, ".Data0"},    bus.Data0, 0);
    check({tag, ".Data1"},    bus.Data1, 0);
    check({tag, ".Data2"},    bus.Data2, 0);
    check({tag, ".Data3"},    bus.Data3, 0);
    check({tag, ".DataOut"},  32'({bus.DataOut3, bus.DataOut2, bus.DataOut1, bus.DataOut0}), 0);
    check({tag, ".DataPos"},  32'(bus.DataPos), 0);
    check({tag, ".RegWrite"}, 32'(bus.RegWrite), 0);
    check({tag, ".Busy"},     32'(bus.Busy), 0);
    check({tag, ".Done"},     32'(bus.Done), 0);
    check({tag, ".Error"},    32'(bus.Error), 0);
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [3:0] m, input logic [1:0] dst,
                              input int lat, input int nr, input logic [3:0][31:0] rd,
                              input logic [3:0][31:0] d, input int nwr, input int ndone,
                              input int nerr, input int wlat, input int elat);
    vec_t v;
    v.addr = a;  v.mask = m;  v.dest = dst;  v.lat = lat;  v.n_reads = nr;
    v.rd = rd;   v.d = d;     v.dout = (nwr > 0) ? m : 4'b0;  v.dpos = dst;
    v.n_wr = nwr;  v.n_done = ndone;  v.n_err = nerr;  v.wr_lat = wlat;  v.err_lat = elat;
    return v;
  endfunction

  // Reference: lanes in ascending mask order; each lane costs one request cycle plus the
  // memory latency; the write follows the last lane, Done one cycle after the write.
  function automatic vec_t model(input logic [31:0] a, input logic [3:0] m,
                                 input logic [1:0] dst, input int lat);
    vec_t e;
    int   n;
    n = 0;
    e.addr = a;  e.mask = m;  e.dest = dst;  e.lat = lat;
    e.rd = '0;   e.d = '0;    e.dout = '0;   e.dpos = '0;
    e.n_wr = 0;  e.n_done = 0;  e.n_err = 0;  e.wr_lat = 0;  e.err_lat = 0;
    if (dst == 2'b11) begin
      e.n_err   = 1;
      e.err_lat = 1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (m[i]) begin
          e.rd[n] = a + 32'(Stride) * 32'(i);
          e.d[i]  = mem_word(e.rd[n]);
          n++;
        end
      end
      e.n_done = 1;
      e.dout   = m;
      e.dpos   = dst;
      if (m != 4'b0) begin
        e.n_wr   = 1;
        e.wr_lat = 1 + n * (1 + lat);
      end
    end
    e.n_reads = n;
    return v_fix(e);
  endfunction

  function automatic vec_t v_fix(input vec_t e);
    return e;
  endfunction

  task automatic run_vec(input vec_t v, input string tag, input bit poke);
    int          r0, w0, dn0, e0;
    int unsigned st;
    bit          finished;
    mem_lat = v.lat;
    r0  = rd_q.size();
    w0  = wr_cnt;
    dn0 = done_cnt;
    e0  = err_cnt;
    @(negedge clk);
    bus.Start    = 1'b1;
    bus.Address  = v.addr;
    bus.LaneMask = v.mask;
    bus.DestPos  = v.dest;
    st = cyc;
    @(negedge clk);
    bus.Start    = 1'b0;
    bus.Address  = $urandom;
    bus.LaneMask = 4'($urandom);
    bus.DestPos  = 2'($urandom);
    finished = 1'b0;
    for (int i = 0; i < 400 && !finished; i++) begin
      if (poke && i == 0) begin
        check({tag, ".busy"}, 32'(bus.Busy), 1);
        bus.Start    = 1'b1;
        bus.Address  = 32'h700;
        bus.LaneMask = 4'b0001;
        bus.DestPos  = 2'b01;
      end else begin
        bus.Start = 1'b0;
      end
      @(negedge clk);
      if (done_cnt > dn0 || err_cnt > e0) finished = 1'b1;
    end
    bus.Start = 1'b0;
    check({tag, ".finished"}, 32'(finished), 1);
    repeat (3) @(negedge clk);
    check({tag, ".n_reads"}, 32'(rd_q.size() - r0), 32'(v.n_reads));
    for (int i = 0; i < v.n_reads; i++) begin
      check($sformatf("%s.rd%0d", tag, i), (r0 + i < rd_q.size()) ? rd_q[r0 + i] : 32'hDEAD_DEAD,
            v.rd[i]);
    end
    check({tag, ".n_wr"},   32'(wr_cnt - w0),   32'(v.n_wr));
    check({tag, ".n_done"}, 32'(done_cnt - dn0), 32'(v.n_done));
    check({tag, ".n_err"},  32'(err_cnt - e0),  32'(v.n_err));
    if (v.n_wr > 0 && wr_cnt > w0) begin
      for (int i = 0; i < 4; i++) check($sformatf("%s.Data%0d", tag, i), wr_data[i], v.d[i]);
      check({tag, ".DataOut"},   32'(wr_dout), 32'(v.dout));
      check({tag, ".DataPos"},   32'(wr_dpos), 32'(v.dpos));
      check({tag, ".wr_lat"},    wr_cyc - st, 32'(v.wr_lat));
      check({tag, ".done_lat"},  done_cyc - wr_cyc, 1);
    end
    if (v.n_err > 0 && err_cnt > e0) check({tag, ".err_lat"}, err_cyc - st, 32'(v.err_lat));
    if (v.n_done > 0 && v.n_wr == 0 && done_cnt > dn0) check({tag, ".done_lat"}, done_cyc - st, 1);
    check({tag, ".idle"}, 32'(bus.Busy), 0);
  endtask

  vec_t tbl[6];

  initial begin
    int r0, w0, dn0;
    bus.Start    = 1'b0;
    bus.Address  = '0;
    bus.LaneMask = '0;
    bus.DestPos  = '0;

    tbl[0] = mk(32'h100, 4'b1111, 2'b01, 1, 4,
                {32'h10C, 32'h108, 32'h104, 32'h100},
                {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1, 1, 0, 9, 0);
    tbl[1] = mk(32'h200, 4'b0101, 2'b10, 1, 2,
                {32'h0, 32'h0, 32'h208, 32'h200},
                {32'h0, 32'hC0DE_0208, 32'h0, 32'hC0DE_0200}, 1, 1, 0, 5, 0);
    tbl[2] = mk(32'hFFFF_FFFC, 4'b0011, 2'b00, 1, 2,
                {32'h0, 32'h0, 32'h0000_0000, 32'hFFFF_FFFC},
                {32'h0, 32'h0, 32'hC0DE_0000, 32'h3F21_FFFC}, 1, 1, 0, 5, 0);
    tbl[3] = mk(32'h300, 4'b1111, 2'b11, 1, 0, '0, '0, 0, 0, 1, 0, 1);
    tbl[4] = mk(32'h400, 4'b0000, 2'b00, 1, 0, '0, '0, 0, 1, 0, 0, 0);
    tbl[5] = mk(32'h500, 4'b1000, 2'b10, 1, 1,
                {32'h0, 32'h0, 32'h0, 32'h50C},
                {32'hC0DE_050C, 32'h0, 32'h0, 32'h0}, 1, 1, 0, 3, 0);

    #2;
    check_zero("reset_state");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("tbl%0d", i), 1'b0);

    // Reset while waiting for memory; the late MemValid must be ignored.
    mem_lat = 3;
    r0  = rd_q.size();
    w0  = wr_cnt;
    dn0 = done_cnt;
    @(negedge clk);
    bus.Start    = 1'b1;
    bus.Address  = 32'h800;
    bus.LaneMask = 4'b1111;
    bus.DestPos  = 2'b01;
    @(negedge clk);
    bus.Start = 1'b0;
    @(negedge clk);
    check("midreset.busy", 32'(bus.Busy), 1);
    reset = 1'b1;
    #1;
    check_zero("midreset");
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("midreset.n_wr",    32'(wr_cnt - w0), 0);
    check("midreset.n_done",  32'(done_cnt - dn0), 0);
    check("midreset.n_reads", 32'(rd_q.size() - r0), 1);
    check("midreset.idle",    32'(bus.Busy), 0);
    check("midreset.Data3",   bus.Data3, 0);

    // Start while busy is dropped, not queued.
    run_vec(model(32'h600, 4'b1111, 2'b00, 1), "busy_ignore", 1'b1);
    r0 = rd_q.size();
    repeat (5) @(negedge clk);
    check("busy_ignore.no_replay", 32'(rd_q.size() - r0), 0);

`ifdef VLU_TIMEOUT_EN
    mem_mute = 1'b1;
    run_vec(mk(32'h900, 4'b0010, 2'b00, 1, 1, {32'h0, 32'h0, 32'h0, 32'h904}, '0,
               0, 0, 1, 0, int'(Tmo) + 2), "timeout", 1'b0);
    mem_mute = 1'b0;
`endif

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      run_vec(model(a, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                    int'($urandom_range(1, 3))), $sformatf("rnd%0d", n), 1'b0);
    end

    check("strobe_hygiene", 32'(bad_cnt), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
